game_render_pipe: RTL and testbench

//  Pipelined, parametrised playfield renderer: successor of the combinational pong renderer.

---
 rtl/game_render_pipe.sv | 240 ++++++++++++++++++++++++
 tb/tb_game_render_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/game_render_pipe.sv
// Three-stage pipelined playfield renderer: ball with soft edge, NUM_PADS pads, border frame
// and background pattern. Game state is double-buffered and swapped at the start of vblank.
module game_render_pipe #(
    parameter int          SCREEN_WIDTH    = 640,
    parameter int          SCREEN_HEIGHT   = 480,
    parameter int          NUM_PADS        = 2,
    parameter int          PAD_WIDTH       = 8,
    parameter int          PAD_HEIGHT      = 64,
    parameter int          PAD_DISTANCE    = 16,
    parameter int          PAD_SPACING     = 32,
    parameter int          BALL_SIZE_INNER = 64,
    parameter int          BALL_EDGE_LOG2  = 6,
    parameter logic [7:0]  BG_LUM          = 8'h60
) (
    input  logic                     clk_vga,
    input  logic                     rst,
    input  logic [11:0]              x,
    input  logic [11:0]              y,
    input  logic                     blank_n_in,
    input  logic                     hs_in,
    input  logic                     vs_in,
    input  logic [5:0]               switch,
    input  logic [12*NUM_PADS-1:0]   pad_pos,
    input  logic [11:0]              ball_x,
    input  logic [11:0]              ball_y,
    input  logic                     state_valid,
    output logic                     state_applied,
    output logic                     VGA_BLANK_N,
    output logic                     VGA_HS,
    output logic                     VGA_VS,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B
);

    localparam logic [11:0] HALF_W = 12'(SCREEN_WIDTH / 2);
    localparam logic [11:0] HALF_H = 12'(SCREEN_HEIGHT / 2);
    localparam logic [23:0] INNER  = 24'(BALL_SIZE_INNER);

    // ---------------- game state: shadow (captured) and active (rendered) ----------------
    logic [11:0] shadow_pad_q [NUM_PADS];
    logic [11:0] shadow_pad_d [NUM_PADS];
    logic [11:0] active_pad_q [NUM_PADS];
    logic [11:0] active_pad_d [NUM_PADS];
    logic [11:0] shadow_bx_q, shadow_bx_d, shadow_by_q, shadow_by_d;
    logic [11:0] active_bx_q, active_bx_d, active_by_q, active_by_d;
    logic        pending_q, pending_d;
    logic        applied_q, applied_d;
    logic        apply_evt;

    always_comb begin
        shadow_pad_d = shadow_pad_q;
        active_pad_d = active_pad_q;
        shadow_bx_d  = shadow_bx_q;
        shadow_by_d  = shadow_by_q;
        active_bx_d  = active_bx_q;
        active_by_d  = active_by_q;
        pending_d    = pending_q;
        applied_d    = 1'b0;
        apply_evt    = (x == 12'd0) && (y == 12'(SCREEN_HEIGHT));
        // The swap reads the old shadow, so a coinciding strobe is kept for the next vblank.
        if (apply_evt && pending_q) begin
            active_pad_d = shadow_pad_q;
            active_bx_d  = shadow_bx_q;
            active_by_d  = shadow_by_q;
            pending_d    = 1'b0;
            applied_d    = 1'b1;
        end
        if (state_valid) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_pad_d[i] = pad_pos[12*i +: 12];
            end
            shadow_bx_d = ball_x;
            shadow_by_d = ball_y;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                shadow_pad_q[i] <= HALF_H;
                active_pad_q[i] <= HALF_H;
            end
            shadow_bx_q <= HALF_W;
            shadow_by_q <= HALF_H;
            active_bx_q <= HALF_W;
            active_by_q <= HALF_H;
            pending_q   <= 1'b0;
            applied_q   <= 1'b0;
        end else begin
            shadow_pad_q <= shadow_pad_d;
            active_pad_q <= active_pad_d;
            shadow_bx_q  <= shadow_bx_d;
            shadow_by_q  <= shadow_by_d;
            active_bx_q  <= active_bx_d;
            active_by_q  <= active_by_d;
            pending_q    <= pending_d;
            applied_q    <= applied_d;
        end
    end

    assign state_applied = applied_q;

    // ---------------- pipeline registers ----------------
    logic [11:0] x1_q, x1_d, y1_q, y1_d, dx1_q, dx1_d, dy1_q, dy1_d;
    logic        frame1_q, frame1_d, blank1_q, blank1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [5:0]  sw1_q, sw1_d;

    logic [23:0] d2_q, d2_d;
    logic [24:0] d_sum;
    logic        fp2_q, fp2_d, blank2_q, blank2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [1:0]  chk2_q, chk2_d;
    logic [5:0]  sw2_q, sw2_d;

    logic [7:0]  rgb_q [3];
    logic [7:0]  rgb_d [3];
    logic        blank3_q, hs3_q, vs3_q;

    logic [NUM_PADS-1:0] pad_hit_vec;

    // Pad column windows are constants; only the y window depends on state.
    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
        localparam int COL = PAD_DISTANCE + (gi / 2) * PAD_SPACING;
        localparam int XL  = (gi % 2 == 0) ? COL : SCREEN_WIDTH - COL - PAD_WIDTH;
        logic x_in, y_in;
        assign x_in = ({1'b0, x1_q} > 13'(XL)) && ({1'b0, x1_q} < 13'(XL + PAD_WIDTH));
        assign y_in = (({1'b0, y1_q} + 13'(PAD_HEIGHT / 2)) > {1'b0, active_pad_q[gi]})
                   && ({1'b0, y1_q} < ({1'b0, active_pad_q[gi]} + 13'(PAD_HEIGHT / 2)));
        assign pad_hit_vec[gi] = x_in & y_in;
    end

    always_comb begin
        // S1
        x1_d     = x;
        y1_d     = y;
        dx1_d    = (x >= active_bx_q) ? (x - active_bx_q) : (active_bx_q - x);
        dy1_d    = (y >= active_by_q) ? (y - active_by_q) : (active_by_q - y);
        frame1_d = (x == 12'd0) || (x == 12'(SCREEN_WIDTH - 1))
                || (y == 12'd0) || (y == 12'(SCREEN_HEIGHT - 1));
        blank1_d = blank_n_in;
        hs1_d    = hs_in;
        vs1_d    = vs_in;
        sw1_d    = switch;
        // S2
        d_sum    = 25'(dx1_q) * 25'(dx1_q) + 25'(dy1_q) * 25'(dy1_q);
        d2_d     = d_sum[24] ? 24'hFFFFFF : d_sum[23:0];
        fp2_d    = frame1_q | (|pad_hit_vec);
        chk2_d   = {x1_q[4] ^ y1_q[4], x1_q[1] ^ y1_q[1]};
        blank2_d = blank1_q;
        hs2_d    = hs1_q;
        vs2_d    = vs1_q;
        sw2_d    = sw1_q;
    end

    // ---------------- S3 colour ----------------
    logic [23:0]               e3;
    logic [BALL_EDGE_LOG2-1:0] lum_inv;
    logic [7:0]                ball_lum, full_lum, fp_lum, bg_lum;
    logic                      bg_on;

    always_comb begin
        e3       = (d2_q >= INNER) ? (d2_q - INNER) : 24'd0;
        lum_inv  = ~e3[BALL_EDGE_LOG2-1:0];
        ball_lum = ((e3 >> BALL_EDGE_LOG2) != 24'd0) ? 8'd0
                 : (8'(lum_inv) << (8 - BALL_EDGE_LOG2));
        fp_lum   = fp2_q ? 8'hFF : 8'h00;
        full_lum = fp2_q ? 8'hFF : ball_lum;
        bg_on    = (sw2_q[0] & chk2_q[0]) | (sw2_q[1] & chk2_q[1]);
        bg_lum   = bg_on ? BG_LUM : 8'h00;
    end

    // Channel 0 is red; with switch[5] the ball lights only the red channel.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        localparam bit IS_RED = (gi == 0);
        logic [7:0] base;
        assign base       = (!IS_RED && sw2_q[5]) ? fp_lum : full_lum;
        assign rgb_d[gi]  = !blank2_q       ? 8'h00
                          : sw2_q[2 + gi]   ? (base | bg_lum)
                          :                   base;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            x1_q     <= '0;
            y1_q     <= '0;
            dx1_q    <= '0;
            dy1_q    <= '0;
            frame1_q <= 1'b0;
            blank1_q <= 1'b0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            sw1_q    <= '0;
            d2_q     <= '0;
            fp2_q    <= 1'b0;
            chk2_q   <= '0;
            blank2_q <= 1'b0;
            hs2_q    <= 1'b1;
            vs2_q    <= 1'b1;
            sw2_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                rgb_q[i] <= 8'h00;
            end
            blank3_q <= 1'b0;
            hs3_q    <= 1'b1;
            vs3_q    <= 1'b1;
        end else begin
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            dx1_q    <= dx1_d;
            dy1_q    <= dy1_d;
            frame1_q <= frame1_d;
            blank1_q <= blank1_d;
            hs1_q    <= hs1_d;
            vs1_q    <= vs1_d;
            sw1_q    <= sw1_d;
            d2_q     <= d2_d;
            fp2_q    <= fp2_d;
            chk2_q   <= chk2_d;
            blank2_q <= blank2_d;
            hs2_q    <= hs2_d;
            vs2_q    <= vs2_d;
            sw2_q    <= sw2_d;
            for (int i = 0; i < 3; i++) begin
                rgb_q[i] <= rgb_d[i];
            end
            blank3_q <= blank2_q;
            hs3_q    <= hs2_q;
            vs3_q    <= vs2_q;
        end
    end

    assign VGA_R       = rgb_q[0];
    assign VGA_G       = rgb_q[1];
    assign VGA_B       = rgb_q[2];
    assign VGA_BLANK_N = blank3_q;
    assign VGA_HS      = hs3_q;
    assign VGA_VS      = vs3_q;

endmodule

// File: tb/tb_game_render_pipe.sv
// Directed bench for game_render_pipe: a pixel/state model predicts each output, a queue
// holds predictions across the 3-cycle pipeline, and state_applied is checked every cycle.
module tb_game_render_pipe;
    localparam int NP = 4;

    logic              clk_vga = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       x = '0, y = '0;
    logic              blank_n_in = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [5:0]        switch = '0;
    logic [11:0]       pad_in [NP];
    logic [12*NP-1:0]  pad_pos;
    logic [11:0]       bx_in = 12'd320, by_in = 12'd240;
    logic              state_valid = 1'b0;
    logic              state_applied, VGA_BLANK_N, VGA_HS, VGA_VS;
    logic [7:0]        VGA_R, VGA_G, VGA_B;

    for (genvar gi = 0; gi < NP; gi++) begin : g_pp
        assign pad_pos[12*gi +: 12] = pad_in[gi];
    end

    game_render_pipe #(.NUM_PADS(NP)) dut (
        .clk_vga(clk_vga), .rst(rst), .x(x), .y(y), .blank_n_in(blank_n_in),
        .hs_in(hs_in), .vs_in(vs_in), .switch(switch), .pad_pos(pad_pos),
        .ball_x(bx_in), .ball_y(by_in), .state_valid(state_valid),
        .state_applied(state_applied), .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk_vga = ~clk_vga;

    int checks = 0;
    int errors = 0;

    // Reference game state
    int act_bx = 320, act_by = 240, sh_bx = 320, sh_by = 240;
    int act_pad [NP];
    int sh_pad  [NP];
    bit pend = 1'b0;

    localparam logic [26:0] IDLE = {24'h000000, 1'b0, 1'b1, 1'b1};
    logic [26:0] exp_q [$];
    string       tag_q [$];

    function automatic logic [26:0] model(input int xx, input int yy, input logic bl,
                                          input logic h, input logic v, input logic [5:0] sw);
        int dx, dy, d, e, lum, f, fp, bb, r, g, b, gb, col, xl;
        bit frame, pad, bgv;
        dx = (xx > act_bx) ? xx - act_bx : act_bx - xx;
        dy = (yy > act_by) ? yy - act_by : act_by - yy;
        d  = dx * dx + dy * dy;
        if (d > 32'hFFFFFF) d = 32'hFFFFFF;
        e   = (d >= 64) ? d - 64 : 0;
        lum = (e >= 64) ? 0 : (63 - e) * 4;
        frame = (xx == 0) || (xx == 639) || (yy == 0) || (yy == 479);
        pad = 1'b0;
        for (int i = 0; i < NP; i++) begin
            col = 16 + (i / 2) * 32;
            xl  = (i % 2 == 0) ? col : 640 - col - 8;
            if (xx > xl && xx < xl + 8 && yy + 32 > act_pad[i] && yy < act_pad[i] + 32)
                pad = 1'b1;
        end
        f   = (frame || pad) ? 255 : lum;
        fp  = (frame || pad) ? 255 : 0;
        bgv = (sw[0] && (((xx >> 1) ^ (yy >> 1)) & 1) == 1)
           || (sw[1] && (((xx >> 4) ^ (yy >> 4)) & 1) == 1);
        bb  = bgv ? 'h60 : 0;
        r   = sw[2] ? (f | bb) : f;
        gb  = sw[5] ? fp : f;
        g   = sw[3] ? (gb | bb) : gb;
        b   = sw[4] ? (gb | bb) : gb;
        if (!bl) begin r = 0; g = 0; b = 0; end
        return {8'(r), 8'(g), 8'(b), bl, h, v};
    endfunction

    task automatic step(input int xx, input int yy, input logic bl, input logic h,
                        input logic v, input logic sv, input string tag);
        logic [26:0] e, obs, exp_v;
        logic        app_exp;
        string       t;
        x = 12'(xx); y = 12'(yy);
        blank_n_in = bl; hs_in = h; vs_in = v; state_valid = sv;
        e = model(xx, yy, bl, h, v, switch);
        app_exp = 1'b0;
        if (rst) begin
            act_bx = 320; act_by = 240; sh_bx = 320; sh_by = 240; pend = 1'b0;
            for (int i = 0; i < NP; i++) begin act_pad[i] = 240; sh_pad[i] = 240; end
        end else begin
            if (xx == 0 && yy == 480 && pend) begin
                act_bx = sh_bx; act_by = sh_by;
                for (int i = 0; i < NP; i++) act_pad[i] = sh_pad[i];
                pend = 1'b0; app_exp = 1'b1;
            end
            if (sv) begin
                sh_bx = int'(bx_in); sh_by = int'(by_in);
                for (int i = 0; i < NP; i++) sh_pad[i] = int'(pad_in[i]);
                pend = 1'b1;
            end
        end
        @(posedge clk_vga);
        #1;
        obs = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS};
        if (rst) begin
            exp_q.delete(); tag_q.delete();
            repeat (2) begin exp_q.push_back(IDLE); tag_q.push_back("rst_flush"); end
            checks++;
            assert (obs === IDLE) else begin
                errors++;
                $error("FAIL %s: rgb/blank/hs/vs observed %h expected %h", tag, obs, IDLE);
            end
        end else begin
            exp_q.push_back(e); tag_q.push_back(tag);
            if (exp_q.size() >= 3) begin
                exp_v = exp_q.pop_front(); t = tag_q.pop_front();
                checks++;
                assert (obs === exp_v) else begin
                    errors++;
                    $error("FAIL %s: rgb/blank/hs/vs observed %h expected %h", t, obs, exp_v);
                end
            end
        end
        checks++;
        assert (state_applied === app_exp) else begin
            errors++;
            $error("FAIL %s_applied: state_applied observed %b expected %b", tag, state_applied, app_exp);
        end
        $display("step %-10s x=%0d y=%0d out=%02h%02h%02h b=%b h=%b v=%b applied=%b",
                 tag, xx, yy, VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, state_applied);
        state_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin pad_in[i] = 12'd240; act_pad[i] = 240; sh_pad[i] = 240; end
        // T1: reset held mid-line, then sync tracking
        rst = 1'b1;
        repeat (4) step(200, 10, 1, 0, 0, 0, "rst");
        rst = 1'b0;
        step(201, 10, 1, 1, 0, 0, "sync_a");
        step(202, 10, 0, 0, 1, 0, "sync_b");
        step(203, 10, 1, 1, 1, 0, "sync_c");
        step(204, 10, 0, 0, 0, 0, "sync_d");
        // T2: ball at (100,100)
        bx_in = 12'd100; by_in = 12'd100;
        step(5, 300, 1, 1, 1, 1, "cap_ball");
        step(0, 480, 0, 1, 0, 0, "apply1");
        step(1, 480, 0, 1, 0, 0, "vbl1");
        step(100, 100, 1, 1, 1, 0, "core");
        step(100, 120, 1, 1, 1, 0, "far");
        step(108, 100, 1, 1, 1, 0, "inner_edge");
        step(110, 100, 1, 1, 1, 0, "soft_edge");
        step(101, 101, 1, 1, 1, 0, "near_core");
        step(0, 50, 1, 1, 1, 0, "frame_l");
        step(639, 50, 1, 1, 1, 0, "frame_r");
        step(50, 0, 1, 1, 1, 0, "frame_t");
        step(50, 479, 1, 1, 1, 0, "frame_b");
        step(20, 240, 1, 1, 1, 0, "pad0_in");
        step(20, 272, 1, 1, 1, 0, "pad0_ylim");
        step(16, 240, 1, 1, 1, 0, "pad0_xlim");
        step(620, 240, 1, 1, 1, 0, "pad1_in");
        // T5: distinct pad positions
        pad_in[0] = 12'd100; pad_in[1] = 12'd300; pad_in[2] = 12'd240; pad_in[3] = 12'd400;
        step(5, 300, 1, 1, 1, 1, "cap_pads");
        step(0, 480, 0, 1, 0, 0, "apply2");
        step(52, 240, 1, 1, 1, 0, "pad2_in");
        step(52, 272, 1, 1, 1, 0, "pad2_out");
        step(52, 208, 1, 1, 1, 0, "pad2_top");
        step(52, 209, 1, 1, 1, 0, "pad2_top1");
        step(20, 100, 1, 1, 1, 0, "pad0_new");
        step(588, 400, 1, 1, 1, 0, "pad3_in");
        step(620, 300, 1, 1, 1, 0, "pad1_new");
        // T3: tear-free update
        by_in = 12'd200;
        step(5, 50, 1, 1, 1, 1, "t3_cap");
        step(100, 100, 1, 1, 1, 0, "t3_old");
        step(100, 200, 1, 1, 1, 0, "t3_notyet");
        step(0, 480, 0, 1, 0, 0, "t3_apply");
        step(1, 480, 0, 1, 0, 0, "t3_vbl");
        step(100, 200, 1, 1, 1, 0, "t3_new");
        // T4: strobe coinciding with the apply cycle
        bx_in = 12'd250;
        step(5, 300, 1, 1, 1, 1, "t4_cap250");
        bx_in = 12'd300;
        step(0, 480, 0, 1, 0, 1, "t4_collide");
        step(250, 200, 1, 1, 1, 0, "t4_at250");
        step(300, 200, 1, 1, 1, 0, "t4_not300");
        step(0, 480, 0, 1, 0, 0, "t4_apply");
        step(300, 200, 1, 1, 1, 0, "t4_at300");
        step(0, 480, 0, 1, 0, 0, "t4_nopend");
        // T6: colour modes
        switch = 6'b000101;
        step(202, 200, 1, 1, 1, 0, "chk_on");
        step(200, 200, 1, 1, 1, 0, "chk_off");
        switch = 6'b011110;
        step(216, 200, 1, 1, 1, 0, "chk16");
        step(202, 200, 1, 1, 1, 0, "chk_gb");
        switch = 6'b100000;
        step(300, 200, 1, 1, 1, 0, "red_ball");
        step(20, 100, 1, 1, 1, 0, "red_pad");
        switch = 6'b000000;
        step(300, 200, 0, 0, 1, 0, "blanked");
        // Reset mid-frame restores defaults
        rst = 1'b1;
        step(150, 150, 1, 1, 1, 0, "rst2");
        rst = 1'b0;
        step(320, 240, 1, 1, 1, 0, "def_ball");
        step(300, 200, 1, 1, 1, 0, "def_far");
        step(700, 500, 0, 1, 1, 0, "drain1");
        step(700, 500, 0, 1, 1, 0, "drain2");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
